ora_seq_checker: RTL
====================

// Module: ora_seq_checker
// PURPOSE
//  Downstream sink for a via/tpg output port. Accepts packets from a NoC output on a valid/ready handshake.
//  Decodes the {src,dst,id,data} fields and checks them per source node:
//   - destination must equal NODE;
//   - sequence counters must be contiguous for each source.
//  Exposes packet/error statistics and a done flag for end-of-simulation checks.
// PARAMETERS
//  i0_WIDTH      32         packet width
//  N             16         number of NoC nodes
//  N_ADDR_WIDTH  $clog2(N)  router address width
//  NODE          15         router index this checker is attached to
//  i0_ID         0          expected id field value
//  STALL_PERIOD  0          ready drops 1 cycle in every STALL_PERIOD cycles; 0 or 1 = always ready
//  EXPECTED_PKTS 0          done asserts when pkt_count reaches this value; 0 = done never asserts
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 asynchronous reset, ACTIVE-LOW
//  clr          in   1                 synchronous clear of statistics and sequence table
//  i0_data_in   in   i0_WIDTH          packet {src,dst,id,data}
//  i0_valid_in  in   1                 packet valid
//  i0_ready_out out  1                 checker ready
//  pkt_count    out  32                packets accepted and checked, saturating
//  err_count    out  16                packets with any error, saturating
//  err_flag     out  1                 sticky error flag
//  err_code     out  3                 last error: [0] wrong dst, [1] sequence gap, [2] wrong id
//  last_src     out  N_ADDR_WIDTH      src field of the last checked packet
//  last_data    out  i0_WIDTH-2A-8     data field of the last checked packet (A = N_ADDR_WIDTH)
//  done         out  1                 pkt_count >= EXPECTED_PKTS, only when EXPECTED_PKTS != 0
// BEHAVIOUR
//  Field layout (A = N_ADDR_WIDTH, DW = i0_WIDTH-2A-8)
//   src = [W-1 -: A], dst = next A bits, id = next 8 bits, data = [DW-1:0].
//  Reset (rst=0, asynchronous)
//   - All outputs are 0, including i0_ready_out.
//   - The expected-sequence table, exp[0..N-1], is set to 1. Senders increment before their first send, so the first data value is 1.
//   - Reset asserted mid-packet discards any in-flight stage-1 packet.
//  Ready
//   - Registered; first asserted on the first clk edge after rst deasserts.
//   - A stall counter s wraps 0..STALL_PERIOD-1; ready = 0 when s == STALL_PERIOD-1, else 1 (for STALL_PERIOD >= 2).
//  Accept
//   - A packet is accepted on a rising edge where i0_valid_in && i0_ready_out.
//   - Valid without ready is held by the sender and is not consumed.
//  Pipeline, latency 2
//   - Edge k: the accepted packet is captured into stage 1.
//   - Edge k+1: compare and update. pkt_count, err_*, last_* and exp[src] are visible after edge k+1.
//   - Back-to-back accepts are supported at full rate, one per cycle.
//  Compare (stage 2)
//   - e0 = (dst != NODE)
//   - e1 = (data != exp[src])
//   - e2 = (id != i0_ID)
//  Update
//   - exp[src] <= data + 1, DW-bit wrap (max+1 -> 0). This always resyncs, so one gap gives exactly one error.
//   - pkt_count increments, saturating at 2^32-1.
//   - If any error bit is set: err_count increments (saturating at 16'hFFFF), err_flag <= 1, err_code <= {e2,e1,e0}.
//   - err_code is unchanged on clean packets.
//   - last_src and last_data are updated for every packet.
//  Same-source back-to-back
//   - A stage-2 update of exp[src] is forwarded to a stage-1 packet from the same src in the following cycle.
//   - No false sequence error is permitted.
//  Clear (clr=1 at an edge)
//   - Clears pkt_count, err_count, err_flag, err_code, last_*, done and the stall counter, and sets exp[*] to 1.
//   - Drops both the stage-1 packet and any packet accepted that cycle; dropped packets are not counted.
//   - i0_ready_out stays as computed.
//  Done
//   - Registered; asserts the cycle pkt_count reaches EXPECTED_PKTS and holds until clr or rst.
//  Simulation
//   - Each checked packet logs a CHECK line to reports/output.txt; error lines are also $display'd.
//   - All logging is inside synopsys translate_off.
// TESTING
//  T1 Reset
//   - Stimulus: hold rst=0, then release.
//   - Response: all outputs 0 during reset; i0_ready_out=1 one edge after release; pkt_count=0.
//  T2 In-order stream
//   - Stimulus: N=16, NODE=15; src=3, dst=15, id=0, data=1,2,3,4 back-to-back.
//   - Response: pkt_count=4, err_count=0, last_data=4; pkt_count visible 2 edges after each accept.
//  T3 Sequence gap
//   - Stimulus: src=5, data=1,2,4,5.
//   - Response: err_count=1, err_code=3'b010, err_flag=1, pkt_count=4. Data 5 is clean because of the resync.
//  T4 Wrong dest and wrong id
//   - Stimulus: first packet with dst=7, then a separate packet with id=9.
//   - Response: err_code=3'b001 after the first; err_code=3'b100 after the second; err_count=2.
//  T5 Stall and done
//   - Stimulus: STALL_PERIOD=4, EXPECTED_PKTS=10, valid held high continuously.
//   - Response: ready low 1 cycle in 4; exactly 10 packets accepted by cycle ~14; done=1 the cycle pkt_count becomes 10.
//  T6 clr and reset mid-stream
//   - Stimulus: clr on the same edge as an accept; later, rst pulse with a packet in stage 1.
//   - Response: counters read 0 and the colliding packet is uncounted; the next data=1 from any src is clean.

Source files
------------

// File: rtl/ora_seq_checker.sv
// ---------------------------------------------------------------------------
// ora_seq_checker
//   Sink for one NoC output port. Accepts {src,dst,id,data} packets on a
//   valid/ready handshake and checks each one against this node's address,
//   the expected id value and a per-source contiguous sequence counter.
//   Packet and error statistics plus a done flag are exposed for
//   end-of-simulation checks.
//
//   Pipeline: p0 = handshake edge (packet captured), p1 = compare/update edge.
//   Results are visible two edges after the accepting edge.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active-low
//   clr           synchronous clear of statistics, sequence table and stall
//   i0_data_in    packet {src, dst, id, data}
//   i0_valid_in   packet valid
//   i0_ready_out  registered ready, drops one cycle per STALL_PERIOD
//   pkt_count     packets checked (saturating)
//   err_count     packets with any error (saturating)
//   err_flag      sticky error flag
//   err_code      last error {wrong id, sequence gap, wrong dst}
//   last_src      src field of the last checked packet
//   last_data     data field of the last checked packet
//   done          pkt_count has reached EXPECTED_PKTS (never if 0)
// ---------------------------------------------------------------------------
module ora_seq_checker #(
  parameter int i0_WIDTH      = 32,
  parameter int N             = 16,
  parameter int N_ADDR_WIDTH  = $clog2(N),
  parameter int NODE          = 15,
  parameter int i0_ID         = 0,
  parameter int STALL_PERIOD  = 0,
  parameter int EXPECTED_PKTS = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [i0_WIDTH-1:0]                i0_data_in,
  input  logic                               i0_valid_in,
  output logic                               i0_ready_out,
  output logic [31:0]                        pkt_count,
  output logic [15:0]                        err_count,
  output logic                               err_flag,
  output logic [2:0]                         err_code,
  output logic [N_ADDR_WIDTH-1:0]            last_src,
  output logic [i0_WIDTH-2*N_ADDR_WIDTH-9:0] last_data,
  output logic                               done
);

  localparam int A     = N_ADDR_WIDTH;
  localparam int DW    = i0_WIDTH - 2*A - 8;
  // Table spans the full src address space so any src value indexes safely.
  localparam int DEPTH = 1 << A;
  localparam int SW    = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SW-1:0] S_LAST = SW'((STALL_PERIOD >= 2) ? STALL_PERIOD - 1 : 0);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                 ready_q,     ready_d;
  logic [SW-1:0]        stall_q,     stall_d;
  logic                 vld_p1_q;
  logic [i0_WIDTH-1:0]  pkt_p1_q;
  logic [DW-1:0]        exp_q [DEPTH];
  logic [31:0]          pkt_count_q, pkt_count_d;
  logic [15:0]          err_count_q, err_count_d;
  logic                 err_flag_q,  err_flag_d;
  logic [2:0]           err_code_q,  err_code_d;
  logic [A-1:0]         last_src_q,  last_src_d;
  logic [DW-1:0]        last_data_q, last_data_d;
  logic                 done_q,      done_d;

  logic                 accept;
  logic [A-1:0]         src_p1;
  logic [A-1:0]         dst_p1;
  logic [7:0]           id_p1;
  logic [DW-1:0]        data_p1;
  logic [2:0]           err_p1;

  assign accept = i0_valid_in && ready_q;

  // ---- p0 -> p1: capture the accepted packet ------------------------------
  // A packet accepted on a clearing edge is dropped, never checked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1_q <= 1'b0;
    else      vld_p1_q <= accept && !clr;
  end

  always_ff @(posedge clk) begin
    if (accept) pkt_p1_q <= i0_data_in;
  end

  // ---- p1: decode, compare, update ----------------------------------------
  assign src_p1  = pkt_p1_q[i0_WIDTH-1 -: A];
  assign dst_p1  = pkt_p1_q[i0_WIDTH-A-1 -: A];
  assign id_p1   = pkt_p1_q[DW+7 -: 8];
  assign data_p1 = pkt_p1_q[DW-1:0];

  // exp_q is written on the same edge that checks the packet, so a same-src
  // packet in p1 on the following cycle already reads the updated entry.
  assign err_p1 = {id_p1 != 8'(i0_ID), data_p1 != exp_q[src_p1], dst_p1 != A'(NODE)};

  always_comb begin
    stall_d     = stall_q;
    ready_d     = 1'b1;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    err_code_d  = err_code_q;
    last_src_d  = last_src_q;
    last_data_d = last_data_q;
    done_d      = done_q;

    if (STALL_PERIOD >= 2) begin
      ready_d = (stall_q != S_LAST);
      stall_d = (stall_q == S_LAST) ? '0 : stall_q + SW'(1);
    end

    if (vld_p1_q) begin
      pkt_count_d = sat_inc32(pkt_count_q);
      last_src_d  = src_p1;
      last_data_d = data_p1;
      if (|err_p1) begin
        err_count_d = sat_inc16(err_count_q);
        err_flag_d  = 1'b1;
        err_code_d  = err_p1;
      end
    end

    if ((EXPECTED_PKTS != 0) && (pkt_count_d >= 32'(EXPECTED_PKTS))) done_d = 1'b1;

    // Clear wins over everything except ready, which keeps its computed value.
    if (clr) begin
      stall_d     = '0;
      pkt_count_d = '0;
      err_count_d = '0;
      err_flag_d  = 1'b0;
      err_code_d  = '0;
      last_src_d  = '0;
      last_data_d = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      stall_q     <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
      err_code_q  <= '0;
      last_src_q  <= '0;
      last_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      stall_q     <= stall_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
      err_code_q  <= err_code_d;
      last_src_q  <= last_src_d;
      last_data_q <= last_data_d;
      done_q      <= done_d;
    end
  end

  // Senders pre-increment, so every source starts expecting 1. Writing
  // data+1 on every packet (not exp+1) resyncs after a gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) exp_q[i] <= DW'(1);
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) exp_q[i] <= DW'(1);
    end else if (vld_p1_q) begin
      exp_q[src_p1] <= data_p1 + DW'(1);
    end
  end

  assign i0_ready_out = ready_q;
  assign pkt_count    = pkt_count_q;
  assign err_count    = err_count_q;
  assign err_flag     = err_flag_q;
  assign err_code     = err_code_q;
  assign last_src     = last_src_q;
  assign last_data    = last_data_q;
  assign done         = done_q;

endmodule
